// File: rtl/defuzz_centroid.sv
// -----------------------------------------------------------------------------
// defuzz_centroid
//   Singleton-centroid defuzzifier. Accumulates sum(mu*c) and sum(mu) over a
//   frame of rule terms. After the last term, an 8-step sequential restoring
//   divider computes the crisp output y = sum(mu*c) / sum(mu) (signed Q7.0),
//   and the result is presented on a valid/ready handshake.
//
//   Optional build macro: DEFUZZ_ROUND_EN
//     defined   -> the quotient magnitude is rounded half-away-from-zero
//     undefined -> the quotient is truncated toward zero (default)
//   The latency is the same in both builds.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   a term is present on mu/center/in_last
//   in_ready   block can accept a term (high only while accumulating)
//   mu         rule strength, Q1.15 unsigned; bit 15 is ignored
//   center     singleton position, signed Q7.0
//   in_last    term is the final one of the current frame
//   out_valid  y / zero_den are valid
//   out_ready  consumer accepts y
//   y          crisp output, signed Q7.0
//   zero_den   frame had sum(mu) == 0; y then carries ZERO_Y
//   busy       frame in progress (ACC with >=1 term, DIV, FIN or OUT)
// -----------------------------------------------------------------------------
module defuzz_centroid #(
  parameter int                 ACC_W  = 32,
  parameter int                 DEN_W  = 24,
  parameter logic signed [7:0]  ZERO_Y = 8'sd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       mu,
  input  logic signed [7:0] center,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic signed [7:0] y,
  output logic              zero_den,
  output logic              busy
);

  // Remainder must hold |num| (plus the rounding bias) and den << 7.
  localparam int REM_W = ((ACC_W > DEN_W + 8) ? ACC_W : DEN_W + 8) + 1;

  typedef enum logic [1:0] {
    S_ACC,
    S_DIV,
    S_FIN,
    S_OUT
  } state_e;

  state_e                    state_q, state_d;
  logic signed [ACC_W-1:0]   num_q, num_d;
  logic [DEN_W-1:0]          den_q, den_d;
  logic [15:0]               count_q, count_d;
  logic [REM_W-1:0]          rem_q, rem_d;
  logic [7:0]                quo_q, quo_d;
  logic [2:0]                step_q, step_d;
  logic                      neg_q, neg_d;
  logic signed [7:0]         y_q, y_d;
  logic                      zero_den_q, zero_den_d;
  logic                      out_valid_q, out_valid_d;

  // Bit 15 of mu is defined as don't-care.
  logic unused_mu15;
  assign unused_mu15 = mu[15];

  // Term arithmetic: 16-bit non-negative strength times signed centre.
  logic signed [23:0]        prod;
  logic signed [ACC_W-1:0]   num_sum;
  logic [DEN_W-1:0]          den_sum;
  logic [ACC_W-1:0]          num_abs;
  logic [REM_W-1:0]          rem_init;
  logic [REM_W-1:0]          den_shift;
  logic [8:0]                quo_mag;

  assign prod    = $signed({1'b0, mu[14:0]}) * center;
  assign num_sum = num_q + ACC_W'(prod);
  assign den_sum = den_q + DEN_W'(mu[14:0]);
  assign num_abs = num_sum[ACC_W-1] ? ACC_W'(-num_sum) : ACC_W'(num_sum);

`ifdef DEFUZZ_ROUND_EN
  // Bias by half the divisor so truncation of the magnitude rounds half up.
  assign rem_init = REM_W'(num_abs) + REM_W'(den_sum >> 1);
`else
  assign rem_init = REM_W'(num_abs);
`endif

  assign den_shift = REM_W'(den_q) << step_q;
  assign quo_mag   = {1'b0, quo_q};

  // NOTE: every combinational output gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    den_d       = den_q;
    count_d     = count_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    step_d      = step_q;
    neg_d       = neg_q;
    y_d         = y_q;
    zero_den_d  = zero_den_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      S_ACC: begin
        if (in_valid) begin
          num_d   = num_sum;
          den_d   = den_sum;
          count_d = count_q + 16'd1;
          if (in_last) begin
            state_d = S_DIV;
            step_d  = 3'd7;
            rem_d   = rem_init;
            neg_d   = num_sum[ACC_W-1];
            quo_d   = 8'd0;
          end
        end
      end

      S_DIV: begin
        // One quotient bit per edge, MSB first.
        if (rem_q >= den_shift) begin
          rem_d         = rem_q - den_shift;
          quo_d[step_q] = 1'b1;
        end
        if (step_q == 3'd0) state_d = S_FIN;
        else                step_d  = step_q - 3'd1;
      end

      S_FIN: begin
        if (den_q == '0) begin
          y_d        = ZERO_Y;
          zero_den_d = 1'b1;
        end else begin
          zero_den_d = 1'b0;
          if (neg_q) y_d = (quo_mag > 9'd128) ? -8'sd128 : 8'(9'd0 - quo_mag);
          else       y_d = (quo_mag > 9'd127) ?  8'sd127 : 8'(quo_mag);
        end
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end

      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          num_d       = '0;
          den_d       = '0;
          count_d     = '0;
          state_d     = S_ACC;
        end
      end

      default: state_d = S_ACC;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values sampled at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_ACC;
      num_q       <= '0;
      den_q       <= '0;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      step_q      <= '0;
      neg_q       <= 1'b0;
      y_q         <= '0;
      zero_den_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      den_q       <= den_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      step_q      <= step_d;
      neg_q       <= neg_d;
      y_q         <= y_d;
      zero_den_q  <= zero_den_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_ACC);
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign zero_den  = zero_den_q;
  assign busy      = (state_q != S_ACC) || (count_q != 16'd0);

endmodule

// File: doc/defuzz_centroid.md
Name: defuzz_centroid

Overview:
- Singleton-centroid defuzzifier directly downstream of the trapezoid membership stage.
- Consumes a stream of rule strengths (Q1.15, as produced by the MF/rule layer), each paired with an output singleton centre (signed Q7.0).
- Accumulates Σmu·c and Σmu; on the last term runs an 8-step sequential restoring divider and emits crisp y (signed Q7.0) over a valid/ready handshake.
- No combinational divider; one clock, multi-cycle.

Parameters:
ACC_W, 32, width of signed numerator accumulator (supports ≥512 terms at full scale)
DEN_W, 24, width of unsigned denominator accumulator
ZERO_Y, 0, signed Q7.0 value emitted when Σmu == 0

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  term present on mu/center/in_last
in_ready  out  1  block can accept a term
mu  in  16  rule strength, Q1.15 unsigned, bit15 ignored (treated 0)
center  in  8  singleton position, signed Q7.0
in_last  in  1  term is final of current frame
out_valid  out  1  y valid
out_ready  in  1  consumer accepts y
y  out  8  crisp output, signed Q7.0
zero_den  out  1  qualifies y: frame had Σmu == 0
busy  out  1  frame in progress (ACC with ≥1 term, DIV, or OUT)

Behaviour:
- Reset (async, rst_n=0): state=ACC, num=0, den=0, count=0, y=0, out_valid=0, zero_den=0, busy=0, in_ready=1 after release.
- States: ACC, DIV, FIN, OUT.
- ACC: in_ready=1. On in_valid&in_ready edge: num += signed(mu[14:0]) × center (23-bit product, sign-extended); den += mu[14:0]; busy=1. If in_last → DIV with step=7; magnitude |num| latched into remainder, sign latched.
- DIV: in_ready=0. Each edge for step 7..0: if rem ≥ (den<<step), rem −= den<<step, q[step]=1; after step 0 → FIN. Exactly 8 edges.
- FIN (1 edge): apply sign (truncate toward zero); clamp to −128..127. If den==0: y=ZERO_Y, zero_den=1. Set out_valid=1 → OUT.
- Latency: last term accepted on edge E → out_valid=1 after edge E+9.
- OUT: y, zero_den held stable while out_valid=1 && out_ready=0. On out_valid&out_ready edge: out_valid=0, num=den=0, busy=0 → ACC. in_ready=0 throughout OUT (next term accepted earliest one cycle after handshake).
- in_last on first term: single-term frame, y=center when mu≠0.
- in_valid ignored outside ACC; no term is dropped while in_ready=1.
- Accumulator overflow is not detected; frames are limited by the ACC_W sizing.
- Reset mid-DIV/OUT: frame discarded, outputs return to reset values immediately.

Optional Feature:
- Macro DEFUZZ_ROUND_EN.
- Defined: at DIV entry rem = |num| + (den>>1), giving round-half-away-from-zero on magnitude before the sign is applied; clamp still applies.
- Undefined: pure truncation toward zero.
- Latency is identical in both builds.

Test Plan:
- Single term mu=0x7FFF, center=50, in_last=1 → y=50, zero_den=0, out_valid exactly 9 edges after acceptance.
- Terms (0x6000,10),(0x2000,90,last): num=983040, den=32768 → y=30 in both builds.
- Terms (0x2000,0),(0x4000,10,last) → y=6 truncating; y=7 with DEFUZZ_ROUND_EN. Terms (0x4000,−10),(0x2000,0,last) → y=−6 / −7.
- Terms (0x0000,100),(0x0000,−20,last) → y=0 (ZERO_Y), zero_den=1.
- Backpressure: out_ready=0 for 20 cycles after out_valid → y and zero_den stable, in_ready=0, in_valid pulses ignored. Release out_ready → handshake; next frame of (0x4000,−100),(0x4000,100,last) → y=0.
- rst_n pulsed low during DIV step 4 → out_valid=0, busy=0 immediately. New frame (0x7FFF,−128,last) → y=−128, no residue from the aborted frame.
